// File: rtl/handshake_pkg.sv
// Shared types and default sizing for the handshake bus sender/receiver stages.
package handshake_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } hs_state_t;

    localparam int HS_DATA_W  = 8;
    localparam int HS_PKT_LEN = 16;

endpackage

// File: rtl/handshake_sender.sv
// Upstream source stage: emits a packet of PKT_LEN incrementing words over
// valid/ready, with producer-side bubbles gated by random_valid.
module handshake_sender
    import handshake_pkg::*;
#(
    parameter int DATA_W  = HS_DATA_W,
    parameter int PKT_LEN = HS_PKT_LEN,
    parameter int CNT_W   = $clog2(PKT_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              random_valid,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  tx_count_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_LEN - 1);

    hs_state_t         state_q, state_d;
    logic [DATA_W-1:0] seq_q, seq_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            seq_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // valid_d never looks at ready_i except through a completed transfer,
    // so valid_o has no combinational path from ready_i.
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        xfer    = valid_q && ready_i;

        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    state_d = SEND;
                    seq_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SEND: begin
                busy_d = 1'b1;
                if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        seq_d   = seq_q + DATA_W'(1);
                        data_d  = seq_q + DATA_W'(1);
                        valid_d = random_valid;
                    end
                end else if (!valid_q && random_valid) begin
                    valid_d = 1'b1;
                    data_d  = seq_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign tx_count_o = cnt_q;

endmodule

// File: tb/tb_handshake_sender.sv
// Scoreboard bench for handshake_sender: expected words are queued at start,
// monitors pop and compare on every valid&&ready transfer.
module tb_handshake_sender;

    localparam int DW = 8;
    localparam int PL = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, rv, rdy;
    logic          valid_o, busy_o, done_o;
    logic [DW-1:0] data_o;
    logic [4:0]    tx_count_o;

    logic          start1, rv1, rdy1;
    logic          valid1, busy1, done1;
    logic [DW-1:0] data1;
    logic [0:0]    tx1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    int unsigned exp_q[$];
    int unsigned exp1_q[$];

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    always #5 clk = ~clk;

    handshake_sender #(.DATA_W(DW), .PKT_LEN(PL)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .random_valid(rv), .ready_i(rdy),
        .valid_o(valid_o), .data_o(data_o), .busy_o(busy_o), .done_o(done_o),
        .tx_count_o(tx_count_o)
    );

    handshake_sender #(.DATA_W(DW), .PKT_LEN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .random_valid(rv1), .ready_i(rdy1),
        .valid_o(valid1), .data_o(data1), .busy_o(busy1), .done_o(done1),
        .tx_count_o(tx1)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the PKT_LEN=16 instance: transfer data and AXI hold rules.
    always @(negedge clk) begin
        if (rst_n && prev_stall) begin
            check("stall_valid_hold", 32'(valid_o), 1);
            check("stall_data_hold", 32'(data_o), 32'(prev_data));
        end
        if (rst_n && valid_o && ready_of_dut()) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL xfer_unexpected: got data %0d, expected no transfer", data_o);
            end else begin
                check("xfer_data", 32'(data_o), exp_q.pop_front());
            end
        end
        prev_stall = rst_n && valid_o && !rdy;
        prev_data  = data_o;
    end

    function automatic logic ready_of_dut();
        return rdy;
    endfunction

    always @(negedge clk) begin
        if (rst_n && valid1 && rdy1) begin
            if (exp1_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL xfer1_unexpected: got data %0d, expected no transfer", data1);
            end else begin
                check("xfer1_data", 32'(data1), exp1_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pkt();
        start = 1'b1;
        for (int i = 0; i < PL; i++) exp_q.push_back(i);
        step();
        start = 1'b0;
        check("busy_after_start", 32'(busy_o), 1);
        check("tx_clear_on_start", 32'(tx_count_o), 0);
    endtask

    task automatic wait_done(input int unsigned max_cyc, output int unsigned cyc);
        cyc = 0;
        while (done_o !== 1'b1 && cyc < max_cyc) begin
            step();
            cyc++;
        end
        check("done_seen", 32'(done_o), 1);
    endtask

    task automatic wait_data(input int unsigned v, input int unsigned max_cyc);
        int unsigned c = 0;
        while (!(valid_o === 1'b1 && data_o == DW'(v)) && c < max_cyc) begin
            step();
            c++;
        end
        check("wait_data_reached", 32'(data_o), v);
    endtask

    task automatic check_pkt_end();
        check("done_busy_low", 32'(busy_o), 0);
        check("done_valid_low", 32'(valid_o), 0);
        check("done_tx_count", 32'(tx_count_o), PL);
        check("sb_empty", exp_q.size(), 0);
        step();
        check("done_one_cycle", 32'(done_o), 0);
        check("tx_count_hold", 32'(tx_count_o), PL);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cyc;
        rst_n = 1'b0; start = 1'b0; rv = 1'b0; rdy = 1'b0;
        start1 = 1'b0; rv1 = 1'b1; rdy1 = 1'b1;
        #3;
        check("rst_valid", 32'(valid_o), 0);
        check("rst_data", 32'(data_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_tx", 32'(tx_count_o), 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Full rate packet.
        rv = 1'b1; rdy = 1'b1;
        start_pkt();
        wait_done(100, cyc);
        check("full_rate_cycles", cyc, PL + 1);
        check_pkt_end();
        step();

        // Receiver stall on word 3 with random_valid toggling.
        start_pkt();
        wait_data(3, 50);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rv = ~rv;
            step();
            check("stall_valid", 32'(valid_o), 1);
            check("stall_data", 32'(data_o), 3);
        end
        rdy = 1'b1; rv = 1'b1;
        wait_done(100, cyc);
        check_pkt_end();
        step();

        // Producer bubbles: random_valid alternating.
        rv = 1'b1;
        start_pkt();
        cyc = 0;
        while (done_o !== 1'b1 && cyc < 200) begin
            rv = ~rv;
            step();
            cyc++;
        end
        check("bubble_done_seen", 32'(done_o), 1);
        check_pkt_end();
        rv = 1'b1;
        step();

        // start mid-packet is ignored; start right after DONE restarts from 0.
        start_pkt();
        wait_data(7, 50);
        start = 1'b1;
        step();
        start = 1'b0;
        check("mid_start_no_restart", 32'(tx_count_o) >= 7 ? 1 : 0, 1);
        wait_done(100, cyc);
        check("mid_start_tx", 32'(tx_count_o), PL);
        check("mid_start_sb_empty", exp_q.size(), 0);
        step();
        start_pkt();
        wait_done(100, cyc);
        check_pkt_end();
        step();

        // Asynchronous reset in the middle of a packet.
        start_pkt();
        wait_data(9, 50);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(valid_o), 0);
        check("arst_data", 32'(data_o), 0);
        check("arst_busy", 32'(busy_o), 0);
        check("arst_done", 32'(done_o), 0);
        check("arst_tx", 32'(tx_count_o), 0);
        exp_q.delete();
        step(); step();
        rst_n = 1'b1;
        step();
        check("arst_stays_idle", 32'(valid_o), 0);
        start_pkt();
        wait_done(100, cyc);
        check_pkt_end();
        step();

        // PKT_LEN = 1 instance.
        start1 = 1'b1;
        exp1_q.push_back(0);
        step();
        start1 = 1'b0;
        check("p1_busy", 32'(busy1), 1);
        check("p1_valid_low", 32'(valid1), 0);
        step();
        check("p1_valid", 32'(valid1), 1);
        check("p1_data", 32'(data1), 0);
        step();
        check("p1_done", 32'(done1), 1);
        check("p1_valid_after", 32'(valid1), 0);
        check("p1_busy_after", 32'(busy1), 0);
        check("p1_tx", 32'(tx1), 1);
        check("p1_sb_empty", exp1_q.size(), 0);
        step();
        check("p1_done_pulse", 32'(done1), 0);
        check("p1_valid_idle", 32'(valid1), 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
